// File: rtl/sort_pkg.sv
// Shared definitions for the sorting-network cells.
package sort_pkg;

  localparam int SORT_DEFAULT_WIDTH = 5;
  localparam int SORT_MAX_WIDTH     = 64;

  // True when x is strictly greater than y. Operands arrive already extended
  // to SORT_MAX_WIDTH bits (sign-extended when signed_mode is set), so a
  // single relational compare covers every legal width.
  function automatic logic is_greater(input logic [SORT_MAX_WIDTH-1:0] x,
                                      input logic [SORT_MAX_WIDTH-1:0] y,
                                      input logic                      signed_mode);
    if (signed_mode) begin
      return $signed(x) > $signed(y);
    end
    return x > y;
  endfunction

endpackage

// File: rtl/sort_cmp.sv
// Purely combinational magnitude comparator: gt = (a > b), eq = (a == b),
// using unsigned or two's-complement ordering as selected by SIGNED.
module sort_cmp
  import sort_pkg::*;
#(
  parameter int WIDTH  = SORT_DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq
);

  logic [SORT_MAX_WIDTH-1:0] a_ext;
  logic [SORT_MAX_WIDTH-1:0] b_ext;

  // Extend both operands to the common compare width and compare them.
  always_comb begin
    if (SIGNED) begin
      a_ext = SORT_MAX_WIDTH'($signed(a));
      b_ext = SORT_MAX_WIDTH'($signed(b));
    end else begin
      a_ext = SORT_MAX_WIDTH'(a);
      b_ext = SORT_MAX_WIDTH'(b);
    end
    gt = is_greater(a_ext, b_ext, SIGNED);
    eq = (a == b);
  end

endmodule

// File: rtl/sort_2ip.sv
// Registered two-input compare-exchange cell: g = max(a,b), l = min(a,b),
// one cycle after in_valid. Results hold while in_valid is low.
// Optional status outputs eq/swapped are enabled by defining SORT_2IP_STATUS_EN.
module sort_2ip
  import sort_pkg::*;
#(
  parameter int WIDTH  = SORT_DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] l
`ifdef SORT_2IP_STATUS_EN
  ,
  output logic             eq,
  output logic             swapped
`endif
);

  logic             a_gt_b;
  logic             a_eq_b;
  logic             swap;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] g_d, g_q;
  logic [WIDTH-1:0] l_d, l_q;
`ifdef SORT_2IP_STATUS_EN
  logic             eq_d, eq_q;
  logic             swapped_d, swapped_q;
`endif

  sort_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a  (a),
    .b  (b),
    .gt (a_gt_b),
    .eq (a_eq_b)
  );

  // Exchange only when b is strictly greater; a tie keeps the original order.
  assign swap = ~(a_gt_b | a_eq_b);

  // Next-state: capture the ordered pair on in_valid, otherwise hold data.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    g_d         = g_q;
    l_d         = l_q;
    out_valid_d = in_valid;
`ifdef SORT_2IP_STATUS_EN
    eq_d        = eq_q;
    swapped_d   = swapped_q;
`endif
    if (in_valid) begin
      g_d = swap ? b : a;
      l_d = swap ? a : b;
`ifdef SORT_2IP_STATUS_EN
      eq_d      = a_eq_b;
      swapped_d = swap;
`endif
    end
  end

  // Output registers with synchronous reset taking priority over capture.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      out_valid_q <= 1'b0;
      g_q         <= '0;
      l_q         <= '0;
`ifdef SORT_2IP_STATUS_EN
      eq_q        <= 1'b0;
      swapped_q   <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      g_q         <= g_d;
      l_q         <= l_d;
`ifdef SORT_2IP_STATUS_EN
      eq_q        <= eq_d;
      swapped_q   <= swapped_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign g         = g_q;
  assign l         = l_q;
`ifdef SORT_2IP_STATUS_EN
  assign eq        = eq_q;
  assign swapped   = swapped_q;
`endif

endmodule

// File: tb/tb_sort_2ip.sv
// Self-checking bench for sort_2ip: one unsigned and one signed instance
// (WIDTH=5). Directed vector tables, hand-written hold/stream sequences and a
// randomized run against a value-level max/min reference model.
module tb_sort_2ip;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic         u_in_valid = 1'b0;
  logic [W-1:0] u_a = '0, u_b = '0;
  logic         u_out_valid;
  logic [W-1:0] u_g, u_l;

  logic         s_in_valid = 1'b0;
  logic [W-1:0] s_a = '0, s_b = '0;
  logic         s_out_valid;
  logic [W-1:0] s_g, s_l;

`ifdef SORT_2IP_STATUS_EN
  logic u_eq, u_sw, s_eq, s_sw;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sort_2ip #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (u_in_valid),
    .a         (u_a),
    .b         (u_b),
    .out_valid (u_out_valid),
    .g         (u_g),
    .l         (u_l)
`ifdef SORT_2IP_STATUS_EN
    ,
    .eq        (u_eq),
    .swapped   (u_sw)
`endif
  );

  sort_2ip #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .a         (s_a),
    .b         (s_b),
    .out_valid (s_out_valid),
    .g         (s_g),
    .l         (s_l)
`ifdef SORT_2IP_STATUS_EN
    ,
    .eq        (s_eq),
    .swapped   (s_sw)
`endif
  );

  typedef struct {
    logic         rst;
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ov;
    logic [W-1:0] g;
    logic [W-1:0] l;
    logic         eq;
    logic         sw;
  } vec_t;

  // Reference model state, index 0 = unsigned instance, 1 = signed instance.
  logic         m_ov [2];
  logic [W-1:0] m_g  [2];
  logic [W-1:0] m_l  [2];
  logic         m_eq [2];
  logic         m_sw [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Numeric value of a W-bit operand under the chosen interpretation.
  function automatic int num(input logic [W-1:0] x, input bit sgn);
    if (sgn && x[W-1]) return int'(x) - (1 << W);
    return int'(x);
  endfunction

  // Drive at the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_u(input string tag, input logic ov, input logic [W-1:0] g,
                         input logic [W-1:0] l, input logic eq, input logic sw);
    check({tag, ".u_ov"}, u_out_valid, ov);
    check({tag, ".u_g"},  u_g, g);
    check({tag, ".u_l"},  u_l, l);
`ifdef SORT_2IP_STATUS_EN
    check({tag, ".u_eq"}, u_eq, eq);
    check({tag, ".u_sw"}, u_sw, sw);
`else
    if (eq === 1'bx || sw === 1'bx) $display("note: unknown status expectation in %s", tag);
`endif
  endtask

  task automatic check_s(input string tag, input logic ov, input logic [W-1:0] g,
                         input logic [W-1:0] l, input logic eq, input logic sw);
    check({tag, ".s_ov"}, s_out_valid, ov);
    check({tag, ".s_g"},  s_g, g);
    check({tag, ".s_l"},  s_l, l);
`ifdef SORT_2IP_STATUS_EN
    check({tag, ".s_eq"}, s_eq, eq);
    check({tag, ".s_sw"}, s_sw, sw);
`else
    if (eq === 1'bx || sw === 1'bx) $display("note: unknown status expectation in %s", tag);
`endif
  endtask

  // Apply one cycle of identical inputs to both instances, advance the model
  // from the max/min rules, and compare both instances against it.
  task automatic cycle_both(input string tag, input logic r, input logic v,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    rst = r; u_in_valid = v; u_a = a; u_b = b;
    s_in_valid = v; s_a = a; s_b = b;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_ov[d] = 1'b0; m_g[d] = '0; m_l[d] = '0; m_eq[d] = 1'b0; m_sw[d] = 1'b0;
      end else if (v) begin
        m_ov[d] = 1'b1;
        m_eq[d] = (num(a, d == 1) == num(b, d == 1));
        m_sw[d] = (num(b, d == 1) >  num(a, d == 1));
        m_g[d]  = m_sw[d] ? b : a;
        m_l[d]  = m_sw[d] ? a : b;
      end else begin
        m_ov[d] = 1'b0;
      end
    end
    tick();
    check_u(tag, m_ov[0], m_g[0], m_l[0], m_eq[0], m_sw[0]);
    check_s(tag, m_ov[1], m_g[1], m_l[1], m_eq[1], m_sw[1]);
  endtask

  initial begin
    vec_t uvec[$];
    vec_t svec[$];
    logic [W-1:0] ra, rb;

    // Unsigned instance: reset with pending input, release, ordering, ties, extremes.
    uvec.push_back('{1'b1, 1'b1, 5'd8,  5'd7,  1'b0, 5'd0,  5'd0,  1'b0, 1'b0});
    uvec.push_back('{1'b1, 1'b1, 5'd8,  5'd7,  1'b0, 5'd0,  5'd0,  1'b0, 1'b0});
    uvec.push_back('{1'b0, 1'b1, 5'd8,  5'd7,  1'b1, 5'd8,  5'd7,  1'b0, 1'b0});
    uvec.push_back('{1'b0, 1'b1, 5'd6,  5'd25, 1'b1, 5'd25, 5'd6,  1'b0, 1'b1});
    uvec.push_back('{1'b0, 1'b1, 5'd13, 5'd13, 1'b1, 5'd13, 5'd13, 1'b1, 1'b0});
    uvec.push_back('{1'b0, 1'b1, 5'd0,  5'd31, 1'b1, 5'd31, 5'd0,  1'b0, 1'b1});
    uvec.push_back('{1'b0, 1'b1, 5'd31, 5'd0,  1'b1, 5'd31, 5'd0,  1'b0, 1'b0});
    uvec.push_back('{1'b0, 1'b0, 5'd2,  5'd9,  1'b0, 5'd31, 5'd0,  1'b0, 1'b0});

    // Signed instance: most-negative vs small positive, negatives, extremes.
    svec.push_back('{1'b0, 1'b1, 5'b10000, 5'd1,     1'b1, 5'd1,     5'b10000, 1'b0, 1'b1});
    svec.push_back('{1'b0, 1'b1, 5'b11111, 5'b11110, 1'b1, 5'b11111, 5'b11110, 1'b0, 1'b0});
    svec.push_back('{1'b0, 1'b1, 5'b10000, 5'd15,    1'b1, 5'd15,    5'b10000, 1'b0, 1'b1});
    svec.push_back('{1'b0, 1'b1, 5'd15,    5'b10000, 1'b1, 5'd15,    5'b10000, 1'b0, 1'b0});
    svec.push_back('{1'b0, 1'b1, 5'b10110, 5'b10110, 1'b1, 5'b10110, 5'b10110, 1'b1, 1'b0});
    svec.push_back('{1'b0, 1'b0, 5'd3,     5'd4,     1'b0, 5'b10110, 5'b10110, 1'b1, 1'b0});

    for (int i = 0; i < uvec.size(); i++) begin
      @(negedge clk);
      rst = uvec[i].rst; u_in_valid = uvec[i].v; u_a = uvec[i].a; u_b = uvec[i].b;
      s_in_valid = 1'b0;
      tick();
      check_u($sformatf("uvec%0d", i), uvec[i].ov, uvec[i].g, uvec[i].l, uvec[i].eq, uvec[i].sw);
    end

    for (int i = 0; i < svec.size(); i++) begin
      @(negedge clk);
      rst = svec[i].rst; s_in_valid = svec[i].v; s_a = svec[i].a; s_b = svec[i].b;
      u_in_valid = 1'b0;
      tick();
      check_s($sformatf("svec%0d", i), svec[i].ov, svec[i].g, svec[i].l, svec[i].eq, svec[i].sw);
    end

    // Hold: capture 20/3, then three idle cycles with random operands.
    @(negedge clk);
    rst = 1'b0; s_in_valid = 1'b0; u_in_valid = 1'b1; u_a = 5'd20; u_b = 5'd3;
    tick();
    check_u("hold_cap", 1'b1, 5'd20, 5'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      u_in_valid = 1'b0; u_a = W'($urandom); u_b = W'($urandom);
      tick();
      check_u($sformatf("hold%0d", i), 1'b0, 5'd20, 5'd3, 1'b0, 1'b0);
    end

    // Streaming: reset, then 10 back-to-back pairs with rst during the 6th.
    cycle_both("stream_rst", 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      cycle_both($sformatf("stream%0d", i), (i == 5), 1'b1, ra, rb);
    end

    // Randomized mix of valid, idle and occasional reset cycles.
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      cycle_both($sformatf("rand%0d", i), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sort_2ip.md
Name: sort_2ip

Overview:
- Two-input sorter: accepts two unsigned (or optionally signed) operands, presents the larger on g and the smaller on l.
- Registered, one-cycle-latency pipeline stage with valid qualifier.
- Used as the basic compare-exchange cell in sorting networks and min/max datapaths.

Parameters:
- WIDTH, 5, operand bit width (legal range 1..64).
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b carry a valid pair this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  g/l hold a valid result.
- g  output  WIDTH  greater of the captured pair.
- l  output  WIDTH  lesser of the captured pair.

Behaviour:
- All outputs registered; no combinational path from inputs to outputs.
- Reset: on a clk edge with rst=1: out_valid=0, g=0, l=0 (plus optional outputs =0). rst has priority over in_valid.
- Capture: on a clk edge with rst=0 and in_valid=1:
  - g <= max(a,b), l <= min(a,b), out_valid <= 1.
  - Latency exactly 1 cycle; throughput 1 pair/cycle.
  - No backpressure; no ready signal.
- in_valid=0 (rst=0): out_valid <= 0; g and l hold their previous values (no spurious toggling).
- Compare rule:
  - SIGNED=0: plain unsigned magnitude compare.
  - SIGNED=1: two's-complement compare; MSB is the sign bit.
- Ties (a==b): g=a, l=b (identical values); treated as "not swapped".
- Boundary values 0 and 2^WIDTH-1 (unsigned), and -2^(WIDTH-1) / 2^(WIDTH-1)-1 (signed), compare correctly with no overflow. No arithmetic subtraction required; a direct relational compare is acceptable.
- Output width equals input width; no truncation or extension.
- Reset asserted mid-stream: the next edge clears outputs regardless of in_valid; capture resumes on the first edge with rst=0.

Optional Feature:
- Macro: SORT_2IP_STATUS_EN.
- Defined: adds two registered outputs, both updated under the same capture/hold/reset rules as g/l (reset to 0):
  - eq  output  1: a==b for the captured pair.
  - swapped  output  1: b was strictly greater than a, so the operands were exchanged.
- Undefined: these ports and their logic do not exist; remaining behaviour is identical.

Decomposition:
- Shared package sort_pkg:
  - localparam SORT_DEFAULT_WIDTH = 5.
  - Function is_greater(x, y, signed_mode), used by this block and future sorting-network cells.
- One natural sub-module: sort_cmp, a purely combinational comparator producing gt and eq from a, b and SIGNED. sort_2ip instantiates it, then muxes and registers.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, a=8, b=7 -> out_valid=0, g=0, l=0 throughout; release rst -> next edge g=8, l=7, out_valid=1.
- Unordered pair: a=6, b=25 (6's bitwise inverse) -> after 1 cycle g=25, l=6; swapped=1 if SORT_2IP_STATUS_EN is defined.
- Tie and extremes:
  - a=b=13 -> g=13, l=13, eq=1, swapped=0.
  - a=0, b=31 -> g=31, l=0.
  - a=31, b=0 -> g=31, l=0.
- Hold: valid pair a=20, b=3, then in_valid=0 for 3 cycles with random a/b -> out_valid=0; g=20, l=3 unchanged.
- Signed mode (SIGNED=1, WIDTH=5): a=5'b10000 (-16), b=1 -> g=1, l=5'b10000; a=5'b11111 (-1), b=5'b11110 (-2) -> g=-1, l=-2.
- Streaming: 10 back-to-back random pairs, then rst=1 during the 6th -> each result matches a max/min reference model 1 cycle later; outputs clear at the rst edge; the stream resumes correctly.
